// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART defaults and debug-protocol byte codes
package uart_rx_pkg;
    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD_RATE  = 19_200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_NB_DATA    = 8;
    localparam logic [7:0] CODE_ACK = 8'h06;
    localparam logic [7:0] CODE_NAK = 8'h15;
    localparam logic [7:0] CODE_SOT = 8'h02;
    localparam logic [7:0] CODE_EOT = 8'h04;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status pulses out
interface uart_rx_if #(parameter int NB_DATA = 8);
    logic               i_rx;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_done;
    logic               o_frame_err;
    logic               o_busy;
    modport master (input i_rx, output o_rx_data, o_rx_done, o_frame_err, o_busy);
    modport slave  (output i_rx, input o_rx_data, o_rx_done, o_frame_err, o_busy);
endinterface

// File: rtl/uart_rx_baud_rate_gen.sv
// baud_rate_gen: free-running divider producing one-clk oversample ticks
module baud_rate_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int NB_DIV = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [NB_DIV-1:0] LAST = NB_DIV'(DIV - 1);
    logic [NB_DIV-1:0] r_cnt;
    assign o_tick = r_cnt == LAST;
    // divider counter wraps DIV-1 -> 0 and never stops
    always_ff @(posedge clk) begin
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= o_tick ? '0 : r_cnt + NB_DIV'(1);
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 16x-oversampled serial receiver with framing/break detection
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int NB_DATA      = DEF_NB_DATA,
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int BAUD_RATE    = DEF_BAUD_RATE,
    parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
    parameter int N_STOP_TICKS = 16
) (
    input logic       clk,
    input logic       i_rst,
    uart_rx_if.master bus
);
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        START = 5'b00010,
        DATA  = 5'b00100,
        STOP  = 5'b01000,
        BREAK = 5'b10000
    } state_t;
    localparam int NB_N = NB_DATA > 1 ? $clog2(NB_DATA) : 1;
    localparam logic [NB_N-1:0] N_LAST = NB_N'(NB_DATA - 1);
    localparam logic [3:0] S_MID  = 4'd7;
    localparam logic [3:0] S_LAST = 4'd15;
    localparam logic [3:0] S_STOP = 4'(N_STOP_TICKS - 1);
    state_t             r_state, w_next;
    logic [1:0]         r_sync;
    logic               w_rx, w_tick, w_s_end, w_done, w_ferr, w_busy;
    logic [3:0]         r_s_cnt;
    logic [NB_N-1:0]    r_n_cnt;
    logic [NB_DATA-1:0] r_shreg, r_data;
    logic               r_done, r_ferr;
    baud_rate_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk   (clk),
        .i_rst (i_rst),
        .o_tick(w_tick)
    );
    assign w_rx    = r_sync[1];
    assign w_s_end = (r_state == START && r_s_cnt == S_MID) ||
                     (r_state == DATA  && r_s_cnt == S_LAST) ||
                     (r_state == STOP  && r_s_cnt == S_STOP);
    assign bus.o_rx_data   = r_data;
    assign bus.o_rx_done   = r_done;
    assign bus.o_frame_err = r_ferr;
    assign bus.o_busy      = w_busy;
    // two-flop synchroniser, idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (i_rst) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], bus.i_rx};
    end
    // state register
    always_ff @(posedge clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // next-state: start detection every clk, bit-timing decisions on ticks
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_rx) w_next = START;
            START:   if (w_tick && r_s_cnt == S_MID) w_next = w_rx ? IDLE : DATA;
            DATA:    if (w_tick && r_s_cnt == S_LAST && r_n_cnt == N_LAST) w_next = STOP;
            STOP:    if (w_tick && r_s_cnt == S_STOP) w_next = w_rx ? IDLE : BREAK;
            BREAK:   if (w_rx) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // outputs: stop-bit verdict decoded here and registered below as pulses
    always_comb begin
        w_busy = r_state != IDLE;
        w_done = r_state == STOP && w_tick && r_s_cnt == S_STOP && w_rx;
        w_ferr = r_state == STOP && w_tick && r_s_cnt == S_STOP && !w_rx;
    end
    // datapath: tick counters, LSB-first shift register, output byte and pulses
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_done <= w_done;
            r_ferr <= w_ferr;
            if (w_done) r_data <= r_shreg;
            if (r_state == IDLE) r_s_cnt <= '0;
            else if (w_tick && r_state != BREAK) r_s_cnt <= w_s_end ? '0 : r_s_cnt + 4'd1;
            if (w_tick && r_state == START) r_n_cnt <= '0;
            if (w_tick && r_state == DATA && r_s_cnt == S_LAST) begin
                r_shreg <= {w_rx, r_shreg[NB_DATA-1:1]};
                r_n_cnt <= r_n_cnt + NB_N'(1);
            end
        end
    end
endmodule
